// File: rtl/paddle_pot_emulator_if.sv
// Purpose : bundles the video timing, raw buttons and paddle outputs shared by
//           the button-driven paddle emulator and whatever drives/observes it.
// Latency : none (wires only).
// Backpressure: none; every signal is a level, with no handshake.
// Ports   : master drives hsync/vsync/vpos/btn_*, observes hpaddle/paddle_target/speed/dir_state;
//           slave is the emulator side.
interface paddle_pot_emulator_if;
  logic       hsync;
  logic       vsync;
  logic [8:0] vpos;
  logic       btn_left;
  logic       btn_right;
  logic       hpaddle;
  logic [8:0] paddle_target;
  logic [2:0] speed;
  logic [1:0] dir_state;

  modport master (
    output hsync, vsync, vpos, btn_left, btn_right,
    input  hpaddle, paddle_target, speed, dir_state
  );

  modport slave (
    input  hsync, vsync, vpos, btn_left, btn_right,
    output hpaddle, paddle_target, speed, dir_state
  );
endinterface

// File: rtl/paddle_pot_emulator.sv
// Purpose : replaces an analog paddle pot with two buttons. Per frame it debounces,
//           accelerates and clamps a target position; per line it drives hpaddle low
//           while vpos <= target, so a "latch vpos while hpaddle low" receiver recovers it.
// Latency : hpaddle is 1 clk after vpos; the target moves on the vsync rising edge and
//           reaches the comparator (frame_target) one clk later.
// Backpressure: none; inputs are sampled every clk and the outputs are free-running levels.
// Ports   : clk, reset (async, active high), bus (slave modport of paddle_pot_emulator_if):
//           hsync/vsync/vpos timing in, btn_left/btn_right raw async buttons in,
//           hpaddle, paddle_target, speed, dir_state out.
module paddle_pot_emulator #(
  parameter int POS_MIN         = 0,
  parameter int POS_MAX         = 224,
  parameter int POS_RESET       = 112,
  parameter int DEBOUNCE_FRAMES = 2,
  parameter int ACCEL_FRAMES    = 4,
  parameter int MAX_SPEED       = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  paddle_pot_emulator_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    MOVE_L = 2'd1,
    MOVE_R = 2'd2
  } dir_t;

  localparam logic [8:0]        POS_RESET_V = 9'(POS_RESET);
  localparam logic [8:0]        POS_MIN_V   = 9'(POS_MIN);
  localparam logic [8:0]        POS_MAX_V   = 9'(POS_MAX);
  localparam logic signed [9:0] POS_MIN_S   = 10'(POS_MIN);
  localparam logic signed [9:0] POS_MAX_S   = 10'(POS_MAX);
  localparam logic [2:0]        DEB_V       = 3'(DEBOUNCE_FRAMES);
  localparam logic [3:0]        ACC_V       = 4'(ACCEL_FRAMES);
  localparam logic [2:0]        MAX_SPEED_V = 3'(MAX_SPEED);

  logic [1:0]        left_sync;
  logic [1:0]        right_sync;
  logic              vsync_prev;
  logic              frame_tick;
  logic              tick_d;

  logic              db_left;
  logic              db_right;
  logic [2:0]        cnt_left;
  logic [2:0]        cnt_right;
  logic              db_left_nxt;
  logic              db_right_nxt;
  logic [2:0]        cnt_left_nxt;
  logic [2:0]        cnt_right_nxt;

  dir_t              state;
  dir_t              state_nxt;
  logic [2:0]        speed_r;
  logic [2:0]        speed_nxt;
  logic [3:0]        accel_cnt;
  logic [3:0]        accel_nxt;

  logic [8:0]        target_r;
  logic [8:0]        target_nxt;
  logic [8:0]        frame_target;
  logic signed [9:0] pos_sum;
  logic              hpaddle_r;

  assign frame_tick = bus.vsync & ~vsync_prev;

  // Debounce: a sample that disagrees with the debounced level for DEB_V
  // consecutive ticks flips it; any agreeing tick restarts the count.
  always_comb begin
    db_left_nxt  = db_left;
    cnt_left_nxt = 3'd0;
    if (left_sync[1] != db_left) begin
      if (cnt_left + 3'd1 == DEB_V) db_left_nxt  = ~db_left;
      else                          cnt_left_nxt = cnt_left + 3'd1;
    end

    db_right_nxt  = db_right;
    cnt_right_nxt = 3'd0;
    if (right_sync[1] != db_right) begin
      if (cnt_right + 3'd1 == DEB_V) db_right_nxt  = ~db_right;
      else                           cnt_right_nxt = cnt_right + 3'd1;
    end
  end

  // Direction, speed and position all use the debounced levels that settle
  // on this very tick, so a press is acted on the tick it is accepted.
  always_comb begin
    case ({db_left_nxt, db_right_nxt})
      2'b10:   state_nxt = MOVE_L;
      2'b01:   state_nxt = MOVE_R;
      default: state_nxt = IDLE;
    endcase

    speed_nxt = speed_r;
    accel_nxt = accel_cnt;
    if (state_nxt == IDLE) begin
      speed_nxt = 3'd0;
      accel_nxt = 4'd0;
    end else if (state_nxt != state) begin
      // Fresh start or direct reversal always restarts slow.
      speed_nxt = 3'd1;
      accel_nxt = 4'd0;
    end else if (accel_cnt + 4'd1 == ACC_V) begin
      accel_nxt = 4'd0;
      if (speed_r < MAX_SPEED_V) speed_nxt = speed_r + 3'd1;
    end else begin
      accel_nxt = accel_cnt + 4'd1;
    end

    // One extra sign bit lets a left move below zero be seen and clamped
    // instead of wrapping to the top of the 9-bit range.
    case (state_nxt)
      MOVE_L:  pos_sum = $signed({1'b0, target_r}) - $signed({7'd0, speed_nxt});
      MOVE_R:  pos_sum = $signed({1'b0, target_r}) + $signed({7'd0, speed_nxt});
      default: pos_sum = $signed({1'b0, target_r});
    endcase

    if (pos_sum < POS_MIN_S)      target_nxt = POS_MIN_V;
    else if (pos_sum > POS_MAX_S) target_nxt = POS_MAX_V;
    else                          target_nxt = pos_sum[8:0];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      left_sync    <= 2'b00;
      right_sync   <= 2'b00;
      vsync_prev   <= 1'b0;
      tick_d       <= 1'b0;
      db_left      <= 1'b0;
      db_right     <= 1'b0;
      cnt_left     <= 3'd0;
      cnt_right    <= 3'd0;
      state        <= IDLE;
      speed_r      <= 3'd0;
      accel_cnt    <= 4'd0;
      target_r     <= POS_RESET_V;
      frame_target <= POS_RESET_V;
      hpaddle_r    <= 1'b1;
    end else begin
      left_sync  <= {left_sync[0], bus.btn_left};
      right_sync <= {right_sync[0], bus.btn_right};
      vsync_prev <= bus.vsync;
      tick_d     <= frame_tick;

      if (frame_tick) begin
        db_left   <= db_left_nxt;
        db_right  <= db_right_nxt;
        cnt_left  <= cnt_left_nxt;
        cnt_right <= cnt_right_nxt;
        state     <= state_nxt;
        speed_r   <= speed_nxt;
        accel_cnt <= accel_nxt;
        target_r  <= target_nxt;
      end

      // Comparator copy only moves right after a tick, i.e. during vsync,
      // so the visible part of a frame always sees one value.
      if (tick_d) frame_target <= target_r;

      hpaddle_r <= (bus.vpos > frame_target);
    end
  end

  assign bus.hpaddle       = hpaddle_r;
  assign bus.paddle_target = target_r;
  assign bus.speed         = speed_r;
  assign bus.dir_state     = state;

endmodule
